sdp_fifo_ctrl: RTL and testbench

SDP_FIFO_CTRL -- requirements
Module: sdp_fifo_ctrl

---
 rtl/sdp_fifo_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sdp_fifo_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_fifo_ctrl.sv
// sdp_fifo_ctrl
//   Controller that builds a FIFO out of an external simple-dual-port RAM
//   with a fixed read latency (RD_LAT = 0, 1 or 2). Reads are prefetched from
//   the RAM into a small registered skid FIFO. The skid FIFO drives the read
//   stream, so the RAM latency is hidden and full throughput is kept.
//
//   Optional feature: define SDP_FIFO_CTRL_PARITY_EN to store an even parity
//   bit alongside each word (ram_din[DATA_W]). Parity is checked as words
//   leave the RAM, and a sticky par_err output is raised on any mismatch.
//
// Ports
//   clk, rst_n                   single clock, async active-low reset
//   wr_valid/wr_ready/wr_data    write stream (accepted on valid && ready)
//   rd_valid/rd_ready/rd_data    read stream  (popped on valid && ready)
//   ram_we/ram_waddr/ram_din     RAM write port, driven combinationally
//   ram_raddr/ram_dout           RAM read port, ram_dout RD_LAT cycles later
//   count                        entries held (RAM + in flight + skid)
//   empty                        count == 0
//   ram_full                     RAM holds 2**ADDR_W entries
//   par_err                      sticky parity error (parity build only)
module sdp_fifo_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 2,
`ifdef SDP_FIFO_CTRL_PARITY_EN
  localparam int unsigned RW = DATA_W + 1
`else
  localparam int unsigned RW = DATA_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [RW-1:0]     ram_din,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [RW-1:0]     ram_dout,
  output logic [ADDR_W+1:0] count,
  output logic              empty,
  output logic              ram_full
`ifdef SDP_FIFO_CTRL_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned CW    = ADDR_W + 2;
  localparam int unsigned SD    = RD_LAT + 2;
  localparam int unsigned SPW   = $clog2(SD);

  logic              wr_hs;
  logic              wr_d1;
  logic              issue;
  logic              cap;
  logic              pop;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CW-1:0]     ram_occ;
  logic [CW-1:0]     rd_avail;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     skid_occ;
  logic [SPW-1:0]    skid_wp;
  logic [SPW-1:0]    skid_rp;
  logic [DATA_W-1:0] skid_mem [SD];

  function automatic logic [SPW-1:0] skid_nxt(input logic [SPW-1:0] p);
    return (p == SPW'(SD - 1)) ? '0 : p + 1'b1;
  endfunction

  // Write side
  assign ram_full  = (ram_occ == CW'(DEPTH));
  assign wr_ready  = !ram_full;
  assign wr_hs     = wr_valid && wr_ready;
  // Gated with rst_n so the RAM is never written while reset is held.
  assign ram_we    = wr_hs && rst_n;
  assign ram_waddr = wptr;
`ifdef SDP_FIFO_CTRL_PARITY_EN
  assign ram_din   = {^wr_data, wr_data};
`else
  assign ram_din   = wr_data;
`endif

  // Read issue: only words written at least two cycles ago are eligible,
  // so an issued read never targets the address being written this cycle.
  // In-flight reads plus skid contents never exceed the skid depth, so
  // every returning word has a free skid slot.
  assign issue     = (rd_avail != '0) && ((inflight + skid_occ) < CW'(SD));
  assign ram_raddr = rptr;

  // Read side
  assign rd_valid = (skid_occ != '0);
  assign rd_data  = skid_mem[skid_rp];
  assign pop      = rd_valid && rd_ready;

  assign count = ram_occ + inflight + skid_occ;
  assign empty = (count == '0);

  // In-flight tracking: a valid bit travels alongside each RAM read.
  if (RD_LAT == 0) begin : g_lat0
    assign cap      = issue;
    assign inflight = '0;
  end else begin : g_latn
    logic [RD_LAT-1:0] vld;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= '0;
      end else begin
        vld[0] <= issue;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
          vld[i] <= vld[i-1];
        end
      end
    end

    assign cap = vld[RD_LAT-1];

    always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        inflight = inflight + CW'(vld[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_occ  <= '0;
      rd_avail <= '0;
      wr_d1    <= 1'b0;
      skid_occ <= '0;
      skid_wp  <= '0;
      skid_rp  <= '0;
    end else begin
      wr_d1    <= wr_hs;
      if (wr_hs) wptr <= wptr + 1'b1;
      if (issue) rptr <= rptr + 1'b1;
      ram_occ  <= ram_occ + CW'(wr_hs) - CW'(issue);
      rd_avail <= rd_avail + CW'(wr_d1) - CW'(issue);
      skid_occ <= skid_occ + CW'(cap) - CW'(pop);
      if (cap) skid_wp <= skid_nxt(skid_wp);
      if (pop) skid_rp <= skid_nxt(skid_rp);
    end
  end

  // Skid payload storage holds only data, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cap) skid_mem[skid_wp] <= ram_dout[DATA_W-1:0];
  end

`ifdef SDP_FIFO_CTRL_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (cap && (^ram_dout)) begin
      par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
module tb_sdp_fifo_ctrl;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DEPTH  = 2**ADDR_W;
`ifdef SDP_FIFO_CTRL_PARITY_EN
  localparam int unsigned RW = DATA_W + 1;
`else
  localparam int unsigned RW = DATA_W;
`endif

  logic              clk;
  logic              rst_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [RW-1:0]     ram_din;
  logic [ADDR_W-1:0] ram_raddr;
  logic [RW-1:0]     ram_dout;
  logic [ADDR_W+1:0] count;
  logic              empty;
  logic              ram_full;
`ifdef SDP_FIFO_CTRL_PARITY_EN
  logic              par_err;
`endif

  sdp_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout),
    .count(count), .empty(empty), .ram_full(ram_full)
`ifdef SDP_FIFO_CTRL_PARITY_EN
    , .par_err(par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // External RAM: two-cycle registered read. inj corrupts bit 0 of the
  // stored word to emulate a bad read.
  logic          inj = 1'b0;
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] p1, p2;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din ^ RW'(inj);
    p1 <= mem[ram_raddr];
    p2 <= p1;
  end
  assign ram_dout = p2;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an ordered queue of accepted words. Entries held equals
  // words accepted minus words delivered.
  logic [DATA_W-1:0] exp_q[$];
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] stall_data;
  logic              prev_ok = 1'b0;
  logic              prev_we;
  logic [ADDR_W-1:0] prev_raddr, prev_waddr;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
      prev_ok    = 1'b0;
    end else begin
      chk("count", count, exp_q.size());
      chk("empty", empty, exp_q.size() == 0);
      if (stall_prev) begin
        chk("stall_valid", rd_valid, 1);
        chk("stall_data", rd_data, stall_data);
      end
      // A change of ram_raddr means a read was issued in the previous cycle.
      if (prev_ok && prev_we && (ram_raddr != prev_raddr))
        chk("rd_wr_same_addr", prev_raddr == prev_waddr, 0);
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL rd_extra: got 0x%0h expected no word (cycle %0d)", rd_data, cyc);
        end else begin
          chk("rd_data", rd_data, exp_q.pop_front());
        end
      end
      if (wr_valid && wr_ready) exp_q.push_back(wr_data ^ DATA_W'(inj));
      stall_prev = rd_valid && !rd_ready;
      stall_data = rd_data;
      prev_ok    = 1'b1;
      prev_we    = ram_we;
      prev_raddr = ram_raddr;
      prev_waddr = ram_waddr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    while ((count != '0 || rd_valid) && n < bound) begin
      step();
      n++;
    end
    chk("drain_timeout", n >= bound, 0);
  endtask

  initial begin
    int acc, sent, got, first, last, stalls, lat, c;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    repeat (3) step();
    wr_valid = 1'b1;
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_raddr", ram_raddr, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ram_full", ram_full, 0);
    wr_valid = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Isolated write: first word visible RD_LAT+3 cycles after handshake.
    rd_ready = 1'b1;
    wr_data  = 32'hA5A5A5A5;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    lat = 1;
    while (!rd_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("first_latency", lat, RD_LAT + 3);
    chk("first_data", rd_data, 32'hA5A5A5A5);
    step();
    chk("empty_after_one", empty, 1);

    // Fill with the read side stalled.
    rd_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      wr_valid = 1'b1;
      wr_data  = $urandom;
      @(negedge clk);
      if (wr_ready) acc++;
      step();
    end
    wr_valid = 1'b0;
    repeat (3) step();
    chk("fill_accepted", acc, DEPTH + RD_LAT + 2);
    chk("fill_count", count, DEPTH + RD_LAT + 2);
    chk("fill_ram_full", ram_full, 1);
    chk("fill_wr_ready", wr_ready, 0);
    drain(200);

    // Streaming through several pointer wraps.
    sent = 0; got = 0; first = 0; last = 0; stalls = 0; c = 0;
    rd_ready = 1'b1;
    while (got < 100 && c < 400) begin
      wr_valid = (sent < 100);
      wr_data  = DATA_W'(sent + 32'h100);
      @(negedge clk);
      if (wr_valid && wr_ready) sent++;
      else if (wr_valid) stalls++;
      if (rd_valid && rd_ready) begin
        if (got == 0) first = c;
        last = c;
        got++;
      end
      step();
      c++;
    end
    wr_valid = 1'b0;
    chk("stream_got", got, 100);
    chk("stream_wr_stalls", stalls, 0);
    chk("stream_rate", last - first, 99);
    drain(50);

    // Random read backpressure.
    sent = 0; got = 0; c = 0;
    while (got < 1000 && c < 20000) begin
      wr_valid = (sent < 1000);
      wr_data  = $urandom;
      rd_ready = ($urandom_range(0, 9) < 3);
      @(negedge clk);
      if (wr_valid && wr_ready) sent++;
      if (rd_valid && rd_ready) got++;
      step();
      c++;
    end
    wr_valid = 1'b0;
    chk("bp_got", got, 1000);
    drain(100);

    // Reset in the middle of traffic.
    rd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1;
      wr_data  = $urandom;
      step();
    end
    wr_valid = 1'b0;
    repeat (4) step();
    chk("mid_count", count, 9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_raddr", ram_raddr, 0);
    step();
    rst_n = 1'b1;
    step();
    wr_valid = 1'b1;
    wr_data  = 32'h0BADCAFE;
    @(negedge clk);
    chk("post_rst_we", ram_we, 1);
    chk("post_rst_waddr", ram_waddr, 0);
    step();
    wr_valid = 1'b0;
    drain(50);

`ifdef SDP_FIFO_CTRL_PARITY_EN
    chk("par_err_clean", par_err, 0);
    inj      = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'h12345678;
    step();
    inj      = 1'b0;
    wr_valid = 1'b0;
    drain(50);
    chk("par_err_set", par_err, 1);
    repeat (5) step();
    chk("par_err_held", par_err, 1);
    rst_n = 1'b0;
    #1;
    chk("par_err_rst", par_err, 0);
    step();
    rst_n = 1'b1;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
